// File: rtl/serial_logic_unit_pkg.sv
// Shared types for the bit-serial logic unit: function codes, route codes, FSM states.
package slu_pkg;

  typedef enum logic [2:0] {
    F_AND   = 3'b000,
    F_OR    = 3'b001,
    F_XOR   = 3'b010,
    F_ONES  = 3'b011,
    F_NAND  = 3'b100,
    F_NOR   = 3'b101,
    F_XNOR  = 3'b110,
    F_ZEROS = 3'b111
  } slu_func_t;

  typedef enum logic [1:0] {
    R_KEEP = 2'b00,  // A<-A, B<-B
    R_B_F  = 2'b01,  // A<-A, B<-f
    R_A_F  = 2'b10,  // A<-f, B<-B
    R_SWAP = 2'b11   // A<-B, B<-A
  } slu_route_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } slu_state_t;

endpackage

// File: rtl/serial_logic_unit_if.sv
// Control/data bundle between a controller (master) and the serial logic unit (slave).
interface serial_logic_unit_if #(parameter int WIDTH = 8) ();
  logic             load_a;
  logic             load_b;
  logic             execute;
  logic [WIDTH-1:0] din;
  logic [2:0]       f;
  logic [1:0]       r;
  logic             dir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;

  modport master (
    output load_a, load_b, execute, din, f, r, dir,
    input  a, b, busy, done
  );

  modport slave (
    input  load_a, load_b, execute, din, f, r, dir,
    output a, b, busy, done
  );
endinterface

// File: rtl/serial_logic_unit_bit_path.sv
// One-bit function + routing slice; purely combinational so it can be replicated per lane.
module slu_bit_path
  import slu_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  slu_func_t  i_func,
  input  slu_route_t i_route,
  output logic       o_a_new,
  output logic       o_b_new
);

  logic w_f;

  always_comb begin
    w_f = 1'b0;
    case (i_func)
      F_AND:   w_f = i_a & i_b;
      F_OR:    w_f = i_a | i_b;
      F_XOR:   w_f = i_a ^ i_b;
      F_ONES:  w_f = 1'b1;
      F_NAND:  w_f = ~(i_a & i_b);
      F_NOR:   w_f = ~(i_a | i_b);
      F_XNOR:  w_f = ~(i_a ^ i_b);
      F_ZEROS: w_f = 1'b0;
      default: w_f = 1'b0;
    endcase
  end

  always_comb begin
    o_a_new = i_a;
    o_b_new = i_b;
    case (i_route)
      R_KEEP: begin o_a_new = i_a; o_b_new = i_b; end
      R_B_F:  begin o_a_new = i_a; o_b_new = w_f; end
      R_A_F:  begin o_a_new = w_f; o_b_new = i_b; end
      R_SWAP: begin o_a_new = i_b; o_b_new = i_a; end
      default: begin o_a_new = i_a; o_b_new = i_b; end
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial logic processor: loads A/B, then WIDTH shifts through slu_bit_path per Execute.
// Op codes are latched at start; HOLD waits for Execute low so a held request runs once.
module serial_logic_unit
  import slu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  serial_logic_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  slu_state_t       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b;
  slu_func_t        r_func;
  slu_route_t       r_route;
  logic             r_dir;
  logic             r_busy, r_done;
  logic             w_busy_next, w_done_next, w_last;
  logic             w_a_out, w_b_out, w_a_new, w_b_new;

  assign w_last  = (r_cnt == LAST);
  assign w_a_out = r_dir ? r_a[WIDTH-1] : r_a[0];
  assign w_b_out = r_dir ? r_b[WIDTH-1] : r_b[0];

  slu_bit_path u_bit_path (
    .i_a     (w_a_out),
    .i_b     (w_b_out),
    .i_func  (r_func),
    .i_route (r_route),
    .o_a_new (w_a_new),
    .o_b_new (w_b_new)
  );

  always_comb begin
    w_next_state = r_state;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.execute) begin
          w_next_state = SHIFT;
          w_busy_next  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = HOLD;
          w_done_next  = 1'b1;
        end else begin
          w_busy_next  = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.execute) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_func  <= F_AND;
      r_route <= R_KEEP;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      case (r_state)
        IDLE: begin
          if (bus.execute) begin
            r_func  <= slu_func_t'(bus.f);
            r_route <= slu_route_t'(bus.r);
            r_dir   <= bus.dir;
            r_cnt   <= '0;
          end else begin
            if (bus.load_a) r_a <= bus.din;
            if (bus.load_b) r_b <= bus.din;
          end
        end
        SHIFT: begin
          // Routed bit re-enters at the far end so WIDTH shifts restore bit positions.
          if (r_dir) begin
            r_a <= {r_a[WIDTH-2:0], w_a_new};
            r_b <= {r_b[WIDTH-2:0], w_b_new};
          end else begin
            r_a <= {w_a_new, r_a[WIDTH-1:1]};
            r_b <= {w_b_new, r_b[WIDTH-1:1]};
          end
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a    = r_a;
  assign bus.b    = r_b;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed-vector bench for serial_logic_unit at WIDTH=8 with hand-computed results.
module tb_serial_logic_unit;

  localparam int W = 8;

  logic i_clk = 1'b0;
  logic i_reset;
  int   vectors = 0;
  int   errors  = 0;

  serial_logic_unit_if #(.WIDTH(W)) bus ();

  serial_logic_unit #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] va, input logic [7:0] vb);
    bus.din = va; bus.load_a = 1'b1;
    tick();
    bus.load_a = 1'b0; bus.din = vb; bus.load_b = 1'b1;
    tick();
    bus.load_b = 1'b0;
  endtask

  // Pulse Execute for one edge, then track Busy/Done until the run completes.
  task automatic run(input string tag, input logic [2:0] f, input logic [1:0] r,
                     input logic dir, input bit disturb,
                     input logic [7:0] exp_a, input logic [7:0] exp_b);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    bus.f = f; bus.r = r; bus.dir = dir; bus.execute = 1'b1;
    tick();
    bus.execute = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      if (disturb && i == 1) begin
        bus.load_a = 1'b1; bus.din = 8'hAA; bus.f = 3'b111; bus.r = 2'b00; bus.dir = ~dir;
      end
      if (disturb && i == 5) bus.load_a = 1'b0;
      tick();
    end
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_done_early"}, done_cnt, 0);
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_busy_end"}, bus.busy, 1'b0);
    chk({tag, "_A"}, bus.a, exp_a);
    chk({tag, "_B"}, bus.b, exp_b);
    tick();
    chk({tag, "_done_drop"}, bus.done, 1'b0);
    tick();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    bus.load_a = 0; bus.load_b = 0; bus.execute = 0;
    bus.din = '0; bus.f = '0; bus.r = '0; bus.dir = 0;
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_A", bus.a, 8'h00);
    chk("rst_B", bus.b, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);

    load(8'h33, 8'h55);
    chk("load_A", bus.a, 8'h33);
    chk("load_B", bus.b, 8'h55);

    run("and_ra", 3'b000, 2'b10, 1'b0, 1'b0, 8'h11, 8'h55);
    load(8'h33, 8'h55);
    run("xor_rb_r", 3'b010, 2'b01, 1'b0, 1'b0, 8'h33, 8'h66);
    load(8'h33, 8'h55);
    run("xor_rb_l", 3'b010, 2'b01, 1'b1, 1'b0, 8'h33, 8'h66);
    load(8'h33, 8'h55);
    run("swap", 3'b100, 2'b11, 1'b0, 1'b0, 8'h55, 8'h33);
    run("ones", 3'b011, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h33);
    load(8'h33, 8'h55);
    run("keep", 3'b111, 2'b00, 1'b1, 1'b0, 8'h33, 8'h55);
    load(8'h33, 8'h55);
    run("nor_ra", 3'b101, 2'b10, 1'b0, 1'b0, 8'h88, 8'h55);

    // Held Execute: one run only.
    load(8'h33, 8'h55);
    bus.f = 3'b000; bus.r = 2'b10; bus.dir = 1'b0; bus.execute = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("held_busy", busy_cnt, 8);
    chk("held_done", done_cnt, 1);
    chk("held_A", bus.a, 8'h11);
    bus.execute = 1'b0;
    tick();
    bus.f = 3'b010; bus.execute = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.execute = 1'b0;
    chk("rerun_done", done_cnt, 1);
    chk("rerun_A", bus.a, 8'h44);
    tick(); tick();

    // Loads and op changes during SHIFT must be ignored.
    load(8'h33, 8'h55);
    run("disturb", 3'b010, 2'b10, 1'b0, 1'b1, 8'h66, 8'h55);
    bus.f = 3'b000; bus.r = 2'b00; bus.dir = 1'b0;

    // Reset on shift edge 4 discards the partial run.
    load(8'h33, 8'h55);
    bus.f = 3'b000; bus.r = 2'b10; bus.execute = 1'b1;
    tick();
    bus.execute = 1'b0;
    tick(); tick(); tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("midrst_A", bus.a, 8'h00);
    chk("midrst_B", bus.b, 8'h00);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    tick();
    chk("midrst_idle_done", bus.done, 1'b0);
    load(8'h33, 8'h55);
    run("post_rst_or", 3'b001, 2'b01, 1'b0, 1'b0, 8'h33, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Parametrised bit-serial logic processor: two WIDTH-bit shift registers A and B are loaded from Din. An Execute request then shifts both registers WIDTH times through a bitwise function/routing path, leaving each register holding its routed result in place. It succeeds the fixed 8-bit button-driven processor datapath. It adds parametrised width, a selectable shift direction, operation codes latched at start, and a Busy/Done handshake so it can sit behind a controller as well as behind synchronised push buttons.

## Interface
- WIDTH, 8, register width in bits; WIDTH >= 2.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- LoadA  in  1  load Din into A (level, sampled each edge).
- LoadB  in  1  load Din into B (level, sampled each edge).
- Execute  in  1  start request (level).
- Din  in  WIDTH  parallel load data.
- F  in  3  function select: 000 AND, 001 OR, 010 XOR, 011 ones, 100 NAND, 101 NOR, 110 XNOR, 111 zeros.
- R  in  2  route select: 00 A<-A, B<-B; 01 A<-A, B<-f; 10 A<-f, B<-B; 11 A<-B, B<-A.
- Dir  in  1  0 = shift right, LSB out, new bit into MSB; 1 = shift left, MSB out, new bit into LSB.
- A  out  WIDTH  register A contents.
- B  out  WIDTH  register B contents.
- Busy  out  1  high while shifting.
- Done  out  1  one-cycle pulse when a run completes.
- All inputs arrive already synchronised to Clk. This block does no synchronisation or debouncing.

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- **IDLE:**
  - LoadA loads A <= Din. LoadB loads B <= Din. Both high loads both.
  - Execute high: capture F, R, Dir into internal latches, clear counter, go to SHIFT. Loads in that same cycle are ignored.
- **SHIFT:**
  - On each edge, take the outgoing bits a and b (A[0], B[0] when Dir=0; A[WIDTH-1], B[WIDTH-1] when Dir=1).
  - Compute f = F(a, b) and route per latched R.
  - Shift both registers one place, inserting the routed bits. Counter increments.
  - On the edge with counter == WIDTH-1: perform the final shift, go to HOLD, assert Done.
  - LoadA, LoadB, and changes to F, R, Dir are ignored.
- **HOLD:** wait for Execute low, then go to IDLE. Loads are ignored.
- Held Execute therefore yields exactly one run.
- Result is independent of Dir: after WIDTH shifts, every bit returns to its original position carrying the routed value.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1.

## Timing
- Reset values: A=0, B=0, Busy=0, Done=0, state IDLE, counter 0, latches 0.
- Reset has priority over every other input in the same edge, including mid-run. A partial run is discarded.
- Load latency: Din appears on A/B one cycle after the edge sampling LoadA/LoadB.
- Run latency: Execute sampled at edge k (IDLE) gives shifts on edges k+1 … k+WIDTH. The final A/B values are visible after edge k+WIDTH.
- Busy is registered: high from after edge k through the cycle ending at edge k+WIDTH.
- Done is registered: high for exactly the one cycle after edge k+WIDTH.
- Minimum spacing between runs: WIDTH+2 cycles. This covers the HOLD exit with Execute dropped immediately.

## Structure
- Package slu_pkg:
  - enum slu_func_t for F codes.
  - enum slu_route_t for R codes.
  - enum slu_state_t {IDLE, SHIFT, HOLD}.
- Sub-module slu_bit_path: combinational f computation plus routing.
  - Inputs: a, b, func, route.
  - Outputs: a_new, b_new.
  - Reused unchanged by future multi-lane variants.
- Top holds the FSM, counter, op latches and both shift registers.

## Test plan
All scenarios use WIDTH=8.
- Load A=0x33, B=0x55; F=000, R=10, Dir=0; pulse Execute -> after 8 shift edges A=0x11, B=0x55; Busy high exactly 8 cycles; Done one cycle.
- Same loads; F=010, R=01 -> A=0x33, B=0x66. Repeat with Dir=1 -> identical result.
- Same loads; R=11, any F -> A=0x55, B=0x33. Then F=011, R=10 -> A=0xFF.
- Execute held high 30 cycles -> exactly one run and one Done pulse. A second run occurs only after Execute goes low then high.
- During SHIFT: assert LoadA with Din=0xAA and change F to 111 -> both ignored; result matches the F captured at start.
- Assert Reset at shift edge 4 -> next cycle A=0, B=0, Busy=0, Done=0; a new Execute starts a clean 8-shift run.
